cmc_sad_search: RTL and testbench

Parametrised, pipelined sum-of-absolute-differences search engine for the CMC codec path. It streams a current block and a sequence of candidate reference blocks in beats of `LANES` pixel pairs. It accumulates an exact SAD per candidate and reports each candidate's saturated SAD. It also tracks the best (minimum) candidate across a search and returns it over a valid/ready handshake, replacing the single-shot 64-pixel SAD PE.

---
 rtl/cmc_pkg.sv | 33 +++
 rtl/cmc_sad_tree.sv | 72 +++++++
 rtl/cmc_sad_search.sv | 167 ++++++++++++++++
 tb/tb_cmc_sad_search.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmc_pkg.sv
// Shared definitions for the CMC SAD search engine.
//   cmc_state_e : search FSM states
//   sat_u       : unsigned saturation of a value to a given bit width
//   idx_w       : clog2 with a minimum of 1 (index/counter widths)
//   packed_w    : width of a lane-packed pixel bus
package cmc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HOLD
  } cmc_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned packed_w(input int unsigned lanes,
                                           input int unsigned pix_w);
    return lanes * pix_w;
  endfunction

  // Clamp v to all-ones of width w when it does not fit in w bits.
  function automatic logic [63:0] sat_u(input logic [63:0] v,
                                        input int unsigned w);
    logic [63:0] lim;
    if (w >= 64) return v;
    lim = (64'd1 << w) - 64'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/cmc_sad_tree.sv
// Two-stage SAD datapath: per-lane |cur-ref| register, then a registered
// adder tree over all lanes. A valid bit and an opaque tag ride alongside
// each beat so the consumer knows which beats are real and where they belong.
//   clk, rst_n        : clock, async active-low reset
//   in_valid, in_tag  : beat qualifier and sideband tag
//   cur_pix, ref_pix  : lane-packed pixels, lane i at [i*PIX_W +: PIX_W]
//   sum_valid, sum_tag: qualifier and tag of the registered tree sum
//   sum               : sum of the lane abs-diffs of one beat
module cmc_sad_tree
  import cmc_pkg::*;
#(
  parameter int unsigned PIX_W = 16,
  parameter int unsigned LANES = 16,
  parameter int unsigned TAG_W = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  input  logic [TAG_W-1:0]                     in_tag,
  input  logic [packed_w(LANES, PIX_W)-1:0]    cur_pix,
  input  logic [packed_w(LANES, PIX_W)-1:0]    ref_pix,
  output logic                                 sum_valid,
  output logic [TAG_W-1:0]                     sum_tag,
  output logic [PIX_W+$clog2(LANES)-1:0]       sum
);

  localparam int unsigned SUM_W = PIX_W + $clog2(LANES);

  logic [PIX_W-1:0] diff_d [LANES];
  logic [PIX_W-1:0] diff_q [LANES];
  logic             diff_valid;
  logic [TAG_W-1:0] diff_tag;
  logic [SUM_W-1:0] sum_d;

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      diff_d[i] = (cur_pix[i*PIX_W +: PIX_W] >= ref_pix[i*PIX_W +: PIX_W])
                ? cur_pix[i*PIX_W +: PIX_W] - ref_pix[i*PIX_W +: PIX_W]
                : ref_pix[i*PIX_W +: PIX_W] - cur_pix[i*PIX_W +: PIX_W];
    end
  end

  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sum_d = sum_d + SUM_W'(diff_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_valid <= 1'b0;
      diff_tag   <= '0;
      for (int unsigned i = 0; i < LANES; i++) diff_q[i] <= '0;
      sum_valid  <= 1'b0;
      sum_tag    <= '0;
      sum        <= '0;
    end else begin
      diff_valid <= in_valid;
      if (in_valid) begin
        diff_tag <= in_tag;
        for (int unsigned i = 0; i < LANES; i++) diff_q[i] <= diff_d[i];
      end
      sum_valid <= diff_valid;
      if (diff_valid) begin
        sum_tag <= diff_tag;
        sum     <= sum_d;
      end
    end
  end

endmodule

// File: rtl/cmc_sad_search.sv
// Pipelined SAD search: streams NUM_CAND candidate blocks of BLOCK_PIX pixels
// in beats of LANES pixel pairs, reports each candidate's saturated SAD and
// returns the minimum over a valid/ready handshake.
//   clk, rst_n                    : clock, async active-low reset
//   start                         : begin a search (IDLE only)
//   in_valid/in_ready             : beat handshake, cur_pix/ref_pix payload
//   cand_valid/cand_sad/cand_idx  : per-candidate result pulse
//   out_valid/out_ready           : search result handshake, best_sad/best_idx
//   busy                          : search in progress (state != IDLE)
module cmc_sad_search
  import cmc_pkg::*;
#(
  parameter int unsigned PIX_W     = 16,
  parameter int unsigned LANES     = 16,
  parameter int unsigned BLOCK_PIX = 64,
  parameter int unsigned NUM_CAND  = 8,
  parameter int unsigned OUT_W     = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [packed_w(LANES, PIX_W)-1:0] cur_pix,
  input  logic [packed_w(LANES, PIX_W)-1:0] ref_pix,
  output logic                              cand_valid,
  output logic [OUT_W-1:0]                  cand_sad,
  output logic [idx_w(NUM_CAND)-1:0]        cand_idx,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_W-1:0]                  best_sad,
  output logic [idx_w(NUM_CAND)-1:0]        best_idx,
  output logic                              busy
);

  localparam int unsigned BEATS  = BLOCK_PIX / LANES;
  localparam int unsigned BEAT_W = idx_w(BEATS);
  localparam int unsigned IDX_W  = idx_w(NUM_CAND);
  localparam int unsigned SUM_W  = PIX_W + $clog2(LANES);
  localparam int unsigned ACC_W  = PIX_W + $clog2(BLOCK_PIX);
  localparam int unsigned TAG_W  = IDX_W + 1;

  cmc_state_e        state;
  logic [BEAT_W-1:0] beat_cnt;
  logic [IDX_W-1:0]  cand_cnt;
  logic [ACC_W-1:0]  acc;

  logic              last_beat;
  logic              last_cand;
  logic [TAG_W-1:0]  beat_tag;

  logic              t_valid;
  logic [TAG_W-1:0]  t_tag;
  logic [SUM_W-1:0]  t_sum;
  logic              t_last;
  logic [IDX_W-1:0]  t_idx;

  logic [ACC_W-1:0]  acc_nxt;
  logic [OUT_W-1:0]  sat_nxt;

  assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
  assign last_cand = (cand_cnt == IDX_W'(NUM_CAND - 1));
  // Tag carries "last beat of a candidate" plus the candidate index so the
  // commit stage needs no counters of its own and bubbles cannot skew it.
  assign beat_tag  = {last_beat, cand_cnt};

  cmc_sad_tree #(
    .PIX_W (PIX_W),
    .LANES (LANES),
    .TAG_W (TAG_W)
  ) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & in_ready),
    .in_tag    (beat_tag),
    .cur_pix   (cur_pix),
    .ref_pix   (ref_pix),
    .sum_valid (t_valid),
    .sum_tag   (t_tag),
    .sum       (t_sum)
  );

  assign t_last = t_tag[TAG_W-1];
  assign t_idx  = t_tag[IDX_W-1:0];

  always_comb begin
    acc_nxt = acc + ACC_W'(t_sum);
    sat_nxt = OUT_W'(sat_u(64'(acc_nxt), OUT_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      cand_valid <= 1'b0;
      cand_sad   <= '0;
      cand_idx   <= '0;
      best_sad   <= '0;
      best_idx   <= '0;
      beat_cnt   <= '0;
      cand_cnt   <= '0;
      acc        <= '0;
    end else begin
      cand_valid <= 1'b0;

      // Accumulate / commit stage, qualified by the tree's valid bit.
      if (t_valid) begin
        if (t_last) begin
          acc        <= '0;
          cand_sad   <= sat_nxt;
          cand_valid <= 1'b1;
          cand_idx   <= t_idx;
          if ((t_idx == '0) || (sat_nxt < best_sad)) begin
            best_sad <= sat_nxt;
            best_idx <= t_idx;
          end
        end else begin
          acc <= acc_nxt;
        end
      end

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            beat_cnt <= '0;
            cand_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            if (last_beat) begin
              beat_cnt <= '0;
              if (last_cand) begin
                state    <= ST_DRAIN;
                in_ready <= 1'b0;
              end else begin
                cand_cnt <= cand_cnt + 1'b1;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (t_valid && t_last && (t_idx == IDX_W'(NUM_CAND - 1))) begin
            state     <= ST_HOLD;
            out_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmc_sad_search.sv
module tb_cmc_sad_search;
  localparam int unsigned PIX_W     = 16;
  localparam int unsigned LANES     = 16;
  localparam int unsigned BLOCK_PIX = 64;
  localparam int unsigned NUM_CAND  = 4;
  localparam int unsigned OUT_W     = 16;
  localparam int unsigned BEATS     = BLOCK_PIX / LANES;
  localparam int unsigned IDX_W     = 2;

  logic                   clk = 1'b0;
  logic                   rst_n, start, in_valid, in_ready;
  logic [LANES*PIX_W-1:0] cur_pix, ref_pix;
  logic                   cand_valid, out_valid, out_ready, busy;
  logic [OUT_W-1:0]       cand_sad, best_sad;
  logic [IDX_W-1:0]       cand_idx, best_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cmc_sad_search #(
    .PIX_W     (PIX_W),
    .LANES     (LANES),
    .BLOCK_PIX (BLOCK_PIX),
    .NUM_CAND  (NUM_CAND),
    .OUT_W     (OUT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cur_pix    (cur_pix),
    .ref_pix    (ref_pix),
    .cand_valid (cand_valid),
    .cand_sad   (cand_sad),
    .cand_idx   (cand_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .best_sad   (best_sad),
    .best_idx   (best_idx),
    .busy       (busy)
  );

  // Stimulus image: one current block, NUM_CAND reference blocks.
  int cur_mem [BLOCK_PIX];
  int ref_mem [NUM_CAND][BLOCK_PIX];

  // Observed per-candidate results.
  int cq_sad [$];
  int cq_idx [$];

  always @(negedge clk) begin
    if (rst_n === 1'b1 && cand_valid === 1'b1) begin
      cq_sad.push_back(int'(cand_sad));
      cq_idx.push_back(int'(cand_idx));
    end
  end

  typedef struct {
    int cur_v;
    int ref_v [NUM_CAND];
    bit gaps;
    int hold;
    int e_sad [NUM_CAND];
    int e_bidx;
    int e_bsad;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: SAD straight from the pixel arrays, saturated to OUT_W.
  function automatic int model_sad(input int c);
    longint s = 0;
    for (int p = 0; p < BLOCK_PIX; p++)
      s += (cur_mem[p] > ref_mem[c][p]) ? cur_mem[p] - ref_mem[c][p]
                                         : ref_mem[c][p] - cur_mem[p];
    return (s > 65535) ? 65535 : int'(s);
  endfunction

  function automatic void model_best(output int bi, output int bs);
    bi = 0;
    bs = model_sad(0);
    for (int c = 1; c < NUM_CAND; c++)
      if (model_sad(c) < bs) begin
        bi = c;
        bs = model_sad(c);
      end
  endfunction

  task automatic set_vec(input int k, input int cv, input int r0, input int r1,
                         input int r2, input int r3, input bit g, input int h,
                         input int s0, input int s1, input int s2, input int s3,
                         input int bi, input int bs);
    tbl[k].cur_v = cv;
    tbl[k].ref_v[0] = r0; tbl[k].ref_v[1] = r1;
    tbl[k].ref_v[2] = r2; tbl[k].ref_v[3] = r3;
    tbl[k].gaps = g;
    tbl[k].hold = h;
    tbl[k].e_sad[0] = s0; tbl[k].e_sad[1] = s1;
    tbl[k].e_sad[2] = s2; tbl[k].e_sad[3] = s3;
    tbl[k].e_bidx = bi;
    tbl[k].e_bsad = bs;
  endtask

  task automatic fill_uniform(input int k);
    for (int p = 0; p < BLOCK_PIX; p++) begin
      cur_mem[p] = tbl[k].cur_v;
      for (int c = 0; c < NUM_CAND; c++) ref_mem[c][p] = tbl[k].ref_v[c];
    end
  endtask

  task automatic fill_random(input int maxv);
    for (int p = 0; p < BLOCK_PIX; p++) begin
      cur_mem[p] = $urandom_range(0, maxv);
      for (int c = 0; c < NUM_CAND; c++) ref_mem[c][p] = $urandom_range(0, maxv);
    end
  endtask

  // Drive beats from the current negedge; stops when all beats are accepted
  // or when beat index stop_at is reached. Returns at a negedge.
  task automatic feed(input bit gaps, input int stop_at, output bit ok);
    int beat = 0;
    int cyc  = 0;
    bit acc;
    ok = 1'b1;
    while (beat < int'(BEATS * NUM_CAND) && beat != stop_at) begin
      if (cyc > 3000) begin
        ok = 1'b0;
        break;
      end
      in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      for (int i = 0; i < LANES; i++) begin
        if (in_valid) begin
          cur_pix[i*PIX_W +: PIX_W] = PIX_W'(cur_mem[(beat % BEATS) * LANES + i]);
          ref_pix[i*PIX_W +: PIX_W] = PIX_W'(ref_mem[beat / BEATS][(beat % BEATS) * LANES + i]);
        end else begin
          cur_pix[i*PIX_W +: PIX_W] = PIX_W'($urandom);
          ref_pix[i*PIX_W +: PIX_W] = PIX_W'($urandom);
        end
      end
      acc = in_valid && (in_ready === 1'b1);
      @(negedge clk);
      cyc++;
      if (acc) beat++;
    end
    in_valid = 1'b0;
  endtask

  // One complete search against the reference model; leaves cq_* filled.
  task automatic do_search(input bit gaps, input int hold_cycles);
    int  bi, bs;
    bit  ok;
    logic [OUT_W-1:0] hold_sad;
    logic [IDX_W-1:0] hold_idx;
    model_best(bi, bs);
    cq_sad.delete();
    cq_idx.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_ready", in_ready, 1);
    feed(gaps, -1, ok);
    check("feed_timeout", ok, 1);
    check("in_ready_drop", in_ready, 0);
    check("out_valid_lat0", out_valid, 0);
    @(negedge clk);
    check("out_valid_lat1", out_valid, 0);
    @(negedge clk);
    check("out_valid_lat2", out_valid, 1);
    check("best_sad", best_sad, bs);
    check("best_idx", best_idx, bi);
    hold_sad = best_sad;
    hold_idx = best_idx;
    for (int k = 0; k < hold_cycles; k++) begin
      start = (k == 3);
      @(negedge clk);
      start = 1'b0;
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_best_sad", best_sad, hold_sad);
      check("hold_best_idx", best_idx, hold_idx);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_out_valid", out_valid, 0);
    check("post_best_sad", best_sad, bs);
    check("cand_count", cq_sad.size(), NUM_CAND);
    if (cq_sad.size() == NUM_CAND)
      for (int c = 0; c < NUM_CAND; c++) begin
        check("cand_sad", cq_sad[c], model_sad(c));
        check("cand_idx", cq_idx[c], c);
      end
  endtask

  task automatic check_table(input int k);
    check("tbl_best_sad", best_sad, tbl[k].e_bsad);
    check("tbl_best_idx", best_idx, tbl[k].e_bidx);
    if (cq_sad.size() == NUM_CAND)
      for (int c = 0; c < NUM_CAND; c++)
        check("tbl_cand_sad", cq_sad[c], tbl[k].e_sad[c]);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cur_pix = '0; ref_pix = '0;

    set_vec(0,   500,   500,   500,   500,   500, 0,  0,     0,   0,   0,   0, 0,   0);
    set_vec(1,   100,   103,    99,   101,    98, 0,  0,   192,  64,  64, 128, 1,  64);
    set_vec(2, 65535,     0, 65530, 65525, 65528, 0,  0, 65535, 320, 640, 448, 1, 320);
    set_vec(3,   100,   103,    99,   101,    98, 1,  0,   192,  64,  64, 128, 1,  64);
    set_vec(4,   100,   103,    99,   101,    98, 0, 10,   192,  64,  64, 128, 1,  64);

    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_cand_valid", cand_valid, 0);
    check("rst_cand_sad", cand_sad, 0);
    check("rst_cand_idx", cand_idx, 0);
    check("rst_best_sad", best_sad, 0);
    check("rst_best_idx", best_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      fill_uniform(k);
      do_search(tbl[k].gaps, tbl[k].hold);
      check_table(k);
    end

    // Reset part-way through candidate 2, then rerun the diff 3/1/1/2 case.
    fill_uniform(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    feed(0, 2 * BEATS + 1, ok);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cand_sad", cand_sad, 0);
    check("mid_rst_best_sad", best_sad, 0);
    check("mid_rst_best_idx", best_idx, 0);
    check("mid_rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cq_sad.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_cand_valid", cand_valid, 0);
      check("post_rst_out_valid", out_valid, 0);
    end
    check("post_rst_no_cand", cq_sad.size(), 0);
    do_search(0, 0);
    check_table(1);

    // Randomised searches against the model (ranges chosen to hit ties,
    // ordinary sums and saturation).
    for (int r = 0; r < 8; r++) begin
      case (r % 4)
        0: fill_random(2);
        1: fill_random(255);
        2: fill_random(2047);
        default: fill_random(65535);
      endcase
      do_search(r[0], (r == 5) ? 3 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
